// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring DIV/DIVU sequencer returning {rem, quo}.
// Optional DIV_EARLY_EXIT_EN skips the loop when |dividend| < |divisor|.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             sq;
  logic             sr;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             take;
  logic             accept;
  logic             dz;
  logic             early;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // operand magnitudes, trial subtraction and sign fix-up
  always_comb begin
    neg_a  = signed_div & opdata1[WIDTH-1];
    neg_b  = signed_div & opdata2[WIDTH-1];
    abs_a  = neg_a ? (~opdata1 + ONE) : opdata1;
    abs_b  = neg_b ? (~opdata2 + ONE) : opdata2;
    trial  = {rem, dvd[WIDTH-1]};
    diff   = trial - {1'b0, dvs};
    take   = ~diff[WIDTH];
    accept = (state == IDLE) & start & ~annul;
    dz     = (opdata2 == '0);
`ifdef DIV_EARLY_EXIT_EN
    early  = ~dz & (abs_a < abs_b);
`else
    early  = 1'b0;
`endif
    q_fix  = sq ? (~dvd + ONE) : dvd;
    r_fix  = sr ? (~rem + ONE) : rem;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next state, stall and ready
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          state_nx = (dz | early) ? DONE : CALC;
        end
      end
      CALC: begin
        if (annul) begin
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt == LAST) state_nx = FIX;
        end
      end
      FIX: begin
        if (annul) begin
          state_nx = IDLE;
        end else begin
          stall    = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        ready    = ~annul;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand capture, iteration datapath and result load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      sq     <= 1'b0;
      sr     <= 1'b0;
      result <= '0;
    end else if (accept) begin
      cnt <= '0;
      dvd <= abs_a;
      dvs <= abs_b;
      rem <= '0;
      sq  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
      sr  <= signed_div & opdata1[WIDTH-1];
      if (dz)
        result <= {opdata1, {WIDTH{1'b1}}};
      else if (early)
        result <= {opdata1, {WIDTH{1'b0}}};
    end else if (state == CALC && !annul) begin
      dvd <= {dvd[WIDTH-2:0], take};
      rem <= take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      cnt <= cnt + CW'(1);
    end else if (state == FIX && !annul) begin
      result <= {r_fix, q_fix};
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, stall shape, signed/unsigned
// results, divide by zero, annul, reset and optional early exit.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int vectors = 0;
  int errors = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_div(signed_div),
    .opdata1(opdata1),
    .opdata2(opdata2),
    .annul(annul),
    .result(result),
    .ready(ready),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic sd, input logic [31:0] a,
                       input logic [31:0] b, output logic st0);
    @(negedge clk);
    signed_div = sd;
    opdata1 = a;
    opdata2 = b;
    start = 1'b1;
    #1 st0 = stall;
  endtask

  task automatic wait_ready(output int lat, output logic stall_ok);
    lat = -1;
    stall_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (ready) begin
        lat = k;
        break;
      end
      if (!stall) stall_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if (ready !== 1'b0 || stall !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset got r=%b s=%b res=%h want 0 0 0",
               ready, stall, result);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_divu_basic;
    int lat;
    logic st0, sok;
    issue(1'b0, 32'd100, 32'd7, st0);
    wait_ready(lat, sok);
    vectors++;
    if (st0 !== 1'b1) begin
      errors++;
      $display("FAIL divu_stall_T got %b want 1", st0);
    end
    vectors++;
    if (lat !== 34 || sok !== 1'b1) begin
      errors++;
      $display("FAIL divu_lat got %0d/%b want 34/1", lat, sok);
    end
    vectors++;
    if (result !== {32'd2, 32'd14} || stall !== 1'b0) begin
      errors++;
      $display("FAIL divu_res got %h s=%b want %h s=0",
               result, stall, {32'd2, 32'd14});
    end
    @(negedge clk);
    #1;
    vectors++;
    if (ready !== 1'b0 || result !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL divu_hold got r=%b %h want 0 %h",
               ready, result, {32'd2, 32'd14});
    end
  endtask

  task automatic test_signed;
    int lat;
    logic st0, sok;
    issue(1'b1, 32'hFFFFFFF9, 32'd2, st0);
    wait_ready(lat, sok);
    vectors++;
    if (lat !== 34 || result !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      errors++;
      $display("FAIL div_neg7_2 got %0d %h want 34 %h", lat, result,
               {32'hFFFFFFFF, 32'hFFFFFFFD});
    end
    issue(1'b0, 32'hFFFFFFF9, 32'd2, st0);
    wait_ready(lat, sok);
    vectors++;
    if (lat !== 34 || result !== {32'd1, 32'h7FFFFFFC}) begin
      errors++;
      $display("FAIL divu_fff9_2 got %0d %h want 34 %h", lat, result,
               {32'd1, 32'h7FFFFFFC});
    end
    issue(1'b1, 32'd7, 32'hFFFFFFFE, st0);
    wait_ready(lat, sok);
    vectors++;
    if (result !== {32'd1, 32'hFFFFFFFD}) begin
      errors++;
      $display("FAIL div_7_neg2 got %h want %h", result,
               {32'd1, 32'hFFFFFFFD});
    end
    issue(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, st0);
    wait_ready(lat, sok);
    vectors++;
    if (result !== {32'hFFFFFFFF, 32'd3}) begin
      errors++;
      $display("FAIL div_neg7_neg2 got %h want %h", result,
               {32'hFFFFFFFF, 32'd3});
    end
  endtask

  task automatic test_overflow_dz;
    int lat;
    logic st0, sok;
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, st0);
    wait_ready(lat, sok);
    vectors++;
    if (lat !== 34 || result !== {32'd0, 32'h80000000}) begin
      errors++;
      $display("FAIL div_ovf got %0d %h want 34 %h", lat, result,
               {32'd0, 32'h80000000});
    end
    issue(1'b0, 32'd5, 32'd0, st0);
    wait_ready(lat, sok);
    vectors++;
    if (st0 !== 1'b1 || lat !== 1 || result !== {32'd5, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL dz_u got s=%b %0d %h want 1 1 %h", st0, lat,
               result, {32'd5, 32'hFFFFFFFF});
    end
    vectors++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL dz_stall got %b want 0", stall);
    end
    issue(1'b1, 32'hFFFFFFFB, 32'd0, st0);
    wait_ready(lat, sok);
    vectors++;
    if (lat !== 1 || result !== {32'hFFFFFFFB, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL dz_s got %0d %h want 1 %h", lat, result,
               {32'hFFFFFFFB, 32'hFFFFFFFF});
    end
  endtask

  task automatic test_annul;
    int lat;
    logic st0, sok;
    logic [63:0] prev;
    prev = result;
    issue(1'b0, 32'd100, 32'd7, st0);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    annul = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL annul_T10 got s=%b r=%b want 0 0", stall, ready);
    end
    @(negedge clk);
    annul = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b0 || ready !== 1'b0 || result !== prev) begin
      errors++;
      $display("FAIL annul_T11 got s=%b r=%b %h want 0 0 %h",
               stall, ready, result, prev);
    end
    issue(1'b0, 32'd9, 32'd3, st0);
    wait_ready(lat, sok);
    vectors++;
    if (lat !== 34 || sok !== 1'b1 || result !== {32'd0, 32'd3}) begin
      errors++;
      $display("FAIL annul_next got %0d/%b %h want 34/1 %h", lat, sok,
               result, {32'd0, 32'd3});
    end
  endtask

  task automatic test_annul_start;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    opdata1 = 32'd8;
    opdata2 = 32'd2;
    start = 1'b1;
    annul = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL annul_start_stall got %b want 0", stall);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      annul = 1'b0;
      #1;
      if (ready || stall) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL annul_start_drop got activity=%b want 0", seen);
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    logic st0, sok;
    issue(1'b0, 32'd1000, 32'd33, st0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    opdata1 = 32'd1;
    opdata2 = 32'd1;
    wait_ready(lat, sok);
    vectors++;
    if (lat !== 29 || result !== {32'd10, 32'd30}) begin
      errors++;
      $display("FAIL midstart got %0d %h want 29 %h", lat, result,
               {32'd10, 32'd30});
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic st0, sok;
    issue(1'b0, 32'd100, 32'd7, st0);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b0 || stall !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid got r=%b s=%b %h want 0 0 0",
               ready, stall, result);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got s=%b r=%b want 0 0", stall, ready);
    end
    issue(1'b0, 32'd100, 32'd7, st0);
    wait_ready(lat, sok);
    vectors++;
    if (lat !== 34 || sok !== 1'b1 || result !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL rst_after got %0d/%b %h want 34/1 %h", lat, sok,
               result, {32'd2, 32'd14});
    end
  endtask

  task automatic test_early;
    int lat;
    int want;
    logic st0, sok;
`ifdef DIV_EARLY_EXIT_EN
    want = 1;
`else
    want = 34;
`endif
    issue(1'b0, 32'd3, 32'd10, st0);
    wait_ready(lat, sok);
    vectors++;
    if (lat !== want || result !== {32'd3, 32'd0}) begin
      errors++;
      $display("FAIL early_u got %0d %h want %0d %h", lat, result,
               want, {32'd3, 32'd0});
    end
    issue(1'b1, 32'hFFFFFFFD, 32'd10, st0);
    wait_ready(lat, sok);
    vectors++;
    if (lat !== want || result !== {32'hFFFFFFFD, 32'd0}) begin
      errors++;
      $display("FAIL early_s got %0d %h want %0d %h", lat, result,
               want, {32'hFFFFFFFD, 32'd0});
    end
    issue(1'b0, 32'd10, 32'd10, st0);
    wait_ready(lat, sok);
    vectors++;
    if (lat !== 34 || result !== {32'd0, 32'd1}) begin
      errors++;
      $display("FAIL early_eq got %0d %h want 34 %h", lat, result,
               {32'd0, 32'd1});
    end
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_signed;
    test_overflow_dz;
    test_annul;
    test_annul_start;
    test_start_ignored;
    test_reset_mid;
    test_early;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
